// File: rtl/vend_pkg.sv
// Shared definitions for the vending_machine payment interface.
// Both the machine and the card responder import this, as do their benches.
package vend_pkg;

  // Width of the COST price bus, in dollars.
  localparam int COST_W = 3;

  // COST value meaning "no sale pending".
  localparam logic [COST_W-1:0] COST_NONE = 3'd0;

  // Card responder states.
  typedef enum logic [2:0] {
    ST_NO_CARD  = 3'd0,
    ST_IDLE     = 3'd1,
    ST_AUTH     = 3'd2,
    ST_APPROVED = 3'd3,
    ST_DECLINE  = 3'd4,
    ST_WAIT_CLR = 3'd5
  } state_e;

endpackage

// File: rtl/auth_timer.sv
// Loadable down-counter that times the authorization latency.
// Clear has priority over load, and load has priority over count.
// The counter stops at zero.
module auth_timer #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         zero_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear, load, decrement, or hold.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = {W{1'b0}};
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != {W{1'b0}})) begin
      count_d = count_q - {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= {W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == {W{1'b0}});

endmodule

// File: rtl/card_payment_responder.sv
// Card/bank side of the vending machine payment interface.
// It reports card presence, prices the pending selection against the stored
// balance after a fixed latency, and debits the balance only on VEND.
// All outputs are taken straight from registers.
module card_payment_responder
  import vend_pkg::*;
#(
  parameter int BAL_W    = 8,
  parameter int AUTH_LAT = 3,
  parameter int MAX_BAL  = 200
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              CARD_INSERT,
  input  logic              CARD_REMOVE,
  input  logic              BAL_LOAD,
  input  logic [BAL_W-1:0]  BAL_LOAD_VAL,
  input  logic [COST_W-1:0] COST,
  input  logic              VEND,
  input  logic              FAILED_TRAN,
  output logic              CARD_IN,
  output logic              VALID_TRAN,
  output logic              DECLINED,
  output logic [BAL_W-1:0]  BALANCE,
  output logic [7:0]        TXN_COUNT
);

  localparam int               SUM_W     = BAL_W + 1;
  localparam logic [SUM_W-1:0] MAX_BAL_S = SUM_W'(MAX_BAL);
  localparam logic [3:0]       TMR_INIT  = 4'(AUTH_LAT - 1);

  state_e            state_q, state_d;
  logic [COST_W-1:0] cost_q, cost_d;
  logic [BAL_W-1:0]  bal_q, bal_d;
  logic [7:0]        txn_q, txn_d;
  logic              card_in_q, card_in_d;
  logic              valid_q, valid_d;
  logic              declined_q, declined_d;

  logic              tmr_load;
  logic              tmr_clr;
  logic              tmr_en;
  logic              tmr_zero;
  logic [SUM_W-1:0]  topup_sum;

  auth_timer #(.W(4)) u_auth_timer (
    .clk_i      (CLK),
    .rst_ni     (RESET_N),
    .clr_i      (tmr_clr),
    .load_i     (tmr_load),
    .load_val_i (TMR_INIT),
    .en_i       (tmr_en),
    .zero_o     (tmr_zero)
  );

  // Next-state, balance and counter logic, plus the next values of the registered outputs.
  always_comb begin
    state_d   = state_q;
    cost_d    = cost_q;
    bal_d     = bal_q;
    txn_d     = txn_q;
    tmr_load  = 1'b0;
    tmr_clr   = 1'b0;
    tmr_en    = 1'b0;
    topup_sum = {1'b0, bal_q} + {1'b0, BAL_LOAD_VAL};

    case (state_q)
      ST_NO_CARD: begin
        if (CARD_INSERT) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_NO_CARD;
        end
      end
      ST_IDLE: begin
        if (COST != COST_NONE) begin
          cost_d   = COST;
          tmr_load = 1'b1;
          state_d  = ST_AUTH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_AUTH: begin
        // The price was latched on entry, so COST is not looked at here.
        if (tmr_zero) begin
          if (bal_q >= BAL_W'(cost_q)) begin
            state_d = ST_APPROVED;
          end else begin
            state_d = ST_DECLINE;
          end
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_APPROVED: begin
        // VEND wins over FAILED_TRAN. Approval already checked the balance, so the debit cannot underflow.
        if (VEND) begin
          bal_d   = bal_q - BAL_W'(cost_q);
          txn_d   = (txn_q == 8'd255) ? 8'd255 : (txn_q + 8'd1);
          state_d = ST_WAIT_CLR;
        end else if (FAILED_TRAN) begin
          state_d = ST_WAIT_CLR;
        end else begin
          state_d = ST_APPROVED;
        end
      end
      ST_DECLINE: begin
        state_d = ST_WAIT_CLR;
      end
      ST_WAIT_CLR: begin
        // Wait until the machine withdraws the sale, so the same sale is not authorized again.
        if ((COST == COST_NONE) && !VEND) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_CLR;
        end
      end
      default: begin
        state_d = ST_NO_CARD;
      end
    endcase

    // A top-up is accepted only when no sale is in progress, so it never races a debit.
    if (BAL_LOAD && ((state_q == ST_NO_CARD) || (state_q == ST_IDLE))) begin
      if (topup_sum > MAX_BAL_S) begin
        bal_d = MAX_BAL_S[BAL_W-1:0];
      end else begin
        bal_d = topup_sum[BAL_W-1:0];
      end
    end else begin
      bal_d = bal_d;
    end

    // Pulling the card aborts everything. A debit computed above in the same cycle is kept.
    if (CARD_REMOVE && (state_q != ST_NO_CARD)) begin
      state_d  = ST_NO_CARD;
      tmr_load = 1'b0;
      tmr_clr  = 1'b1;
    end else begin
      tmr_clr = 1'b0;
    end

    card_in_d  = (state_d != ST_NO_CARD);
    valid_d    = (state_d == ST_APPROVED);
    declined_d = (state_d == ST_DECLINE);
  end

  // State, datapath and output registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= ST_NO_CARD;
      cost_q     <= COST_NONE;
      bal_q      <= {BAL_W{1'b0}};
      txn_q      <= 8'd0;
      card_in_q  <= 1'b0;
      valid_q    <= 1'b0;
      declined_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cost_q     <= cost_d;
      bal_q      <= bal_d;
      txn_q      <= txn_d;
      card_in_q  <= card_in_d;
      valid_q    <= valid_d;
      declined_q <= declined_d;
    end
  end

  assign CARD_IN    = card_in_q;
  assign VALID_TRAN = valid_q;
  assign DECLINED   = declined_q;
  assign BALANCE    = bal_q;
  assign TXN_COUNT  = txn_q;

endmodule

// File: tb/tb_card_payment_responder.sv
// Directed self-checking bench for card_payment_responder.
// Inputs change 1 time unit after the rising edge. Outputs are checked at that same point.
module tb_card_payment_responder;

  logic       CLK;
  logic       RESET_N;
  logic       CARD_INSERT;
  logic       CARD_REMOVE;
  logic       BAL_LOAD;
  logic [7:0] BAL_LOAD_VAL;
  logic [2:0] COST;
  logic       VEND;
  logic       FAILED_TRAN;
  logic       CARD_IN;
  logic       VALID_TRAN;
  logic       DECLINED;
  logic [7:0] BALANCE;
  logic [7:0] TXN_COUNT;

  int n_tests;
  int n_fail;

  card_payment_responder #(.BAL_W(8), .AUTH_LAT(3), .MAX_BAL(200)) dut (
    .CLK          (CLK),
    .RESET_N      (RESET_N),
    .CARD_INSERT  (CARD_INSERT),
    .CARD_REMOVE  (CARD_REMOVE),
    .BAL_LOAD     (BAL_LOAD),
    .BAL_LOAD_VAL (BAL_LOAD_VAL),
    .COST         (COST),
    .VEND         (VEND),
    .FAILED_TRAN  (FAILED_TRAN),
    .CARD_IN      (CARD_IN),
    .VALID_TRAN   (VALID_TRAN),
    .DECLINED     (DECLINED),
    .BALANCE      (BALANCE),
    .TXN_COUNT    (TXN_COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_card_in"}, {31'd0, CARD_IN}, 32'd0);
    check({tag, "_valid"},   {31'd0, VALID_TRAN}, 32'd0);
    check({tag, "_decl"},    {31'd0, DECLINED}, 32'd0);
    check({tag, "_bal"},     {24'd0, BALANCE}, 32'd0);
    check({tag, "_txn"},     {24'd0, TXN_COUNT}, 32'd0);
  endtask

  // Reset in the middle of a clock phase, then release it on a falling edge.
  task automatic do_reset(input string tag);
    @(negedge CLK);
    #2;
    RESET_N = 1'b0;
    #1;
    check_all_zero(tag);
    @(negedge CLK);
    RESET_N = 1'b1;
    tick();
  endtask

  task automatic load(input logic [7:0] v);
    BAL_LOAD = 1'b1;
    BAL_LOAD_VAL = v;
    tick();
    BAL_LOAD = 1'b0;
    BAL_LOAD_VAL = 8'd0;
  endtask

  // COST is applied in IDLE at edge N. Edges N+1 and N+2 must show nothing; N+3 shows the verdict.
  task automatic authorize(input string tag, input logic [2:0] c, input logic exp_valid);
    COST = c;
    tick();
    check({tag, "_n0_valid"}, {31'd0, VALID_TRAN}, 32'd0);
    tick();
    check({tag, "_n1_valid"}, {31'd0, VALID_TRAN}, 32'd0);
    check({tag, "_n1_decl"},  {31'd0, DECLINED}, 32'd0);
    tick();
    check({tag, "_n2_valid"}, {31'd0, VALID_TRAN}, 32'd0);
    check({tag, "_n2_decl"},  {31'd0, DECLINED}, 32'd0);
    tick();
    check({tag, "_n3_valid"}, {31'd0, VALID_TRAN}, {31'd0, exp_valid});
    check({tag, "_n3_decl"},  {31'd0, DECLINED}, {31'd0, !exp_valid});
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    RESET_N = 1'b0;
    CARD_INSERT = 1'b0;
    CARD_REMOVE = 1'b0;
    BAL_LOAD = 1'b0;
    BAL_LOAD_VAL = 8'd0;
    COST = 3'd0;
    VEND = 1'b0;
    FAILED_TRAN = 1'b0;
    #12;
    check_all_zero("rst0");
    @(negedge CLK);
    RESET_N = 1'b1;
    tick();

    // 1: approve COST=3 and vend
    load(8'd10);
    check("t1_load", {24'd0, BALANCE}, 32'd10);
    CARD_INSERT = 1'b1;
    tick();
    CARD_INSERT = 1'b0;
    check("t1_card_in", {31'd0, CARD_IN}, 32'd1);
    authorize("t1", 3'd3, 1'b1);
    VEND = 1'b1;
    tick();
    VEND = 1'b0;
    COST = 3'd0;
    check("t1_bal", {24'd0, BALANCE}, 32'd7);
    check("t1_txn", {24'd0, TXN_COUNT}, 32'd1);
    check("t1_valid_drop", {31'd0, VALID_TRAN}, 32'd0);
    tick();

    // 2: decline with BALANCE=2, COST=5
    do_reset("rst2");
    load(8'd2);
    CARD_INSERT = 1'b1;
    tick();
    CARD_INSERT = 1'b0;
    authorize("t2", 3'd5, 1'b0);
    tick();
    check("t2_decl_pulse", {31'd0, DECLINED}, 32'd0);
    check("t2_valid", {31'd0, VALID_TRAN}, 32'd0);
    check("t2_bal", {24'd0, BALANCE}, 32'd2);
    COST = 3'd0;
    tick();

    // 3: approved COST=4, then FAILED_TRAN
    load(8'd10);
    check("t3_load", {24'd0, BALANCE}, 32'd12);
    authorize("t3", 3'd4, 1'b1);
    FAILED_TRAN = 1'b1;
    tick();
    FAILED_TRAN = 1'b0;
    check("t3_valid_drop", {31'd0, VALID_TRAN}, 32'd0);
    check("t3_bal", {24'd0, BALANCE}, 32'd12);
    check("t3_txn", {24'd0, TXN_COUNT}, 32'd0);
    tick();
    tick();
    check("t3_wait_valid", {31'd0, VALID_TRAN}, 32'd0);
    load(8'd1);
    check("t3_wait_noload", {24'd0, BALANCE}, 32'd12);
    COST = 3'd0;
    tick();
    load(8'd1);
    check("t3_idle_load", {24'd0, BALANCE}, 32'd13);

    // 4: card pulled during AUTH
    COST = 3'd3;
    tick();
    tick();
    CARD_REMOVE = 1'b1;
    tick();
    CARD_REMOVE = 1'b0;
    check("t4_card_in", {31'd0, CARD_IN}, 32'd0);
    check("t4_valid", {31'd0, VALID_TRAN}, 32'd0);
    tick();
    tick();
    check("t4_valid_late", {31'd0, VALID_TRAN}, 32'd0);
    check("t4_bal", {24'd0, BALANCE}, 32'd13);
    load(8'd5);
    check("t4_load", {24'd0, BALANCE}, 32'd18);
    COST = 3'd0;

    // 5: saturation and top-up ignored in APPROVED
    do_reset("rst5");
    load(8'd195);
    check("t5_load195", {24'd0, BALANCE}, 32'd195);
    load(8'd20);
    check("t5_sat", {24'd0, BALANCE}, 32'd200);
    CARD_INSERT = 1'b1;
    tick();
    CARD_INSERT = 1'b0;
    authorize("t5a", 3'd7, 1'b1);
    VEND = 1'b1;
    tick();
    VEND = 1'b0;
    COST = 3'd0;
    check("t5_bal193", {24'd0, BALANCE}, 32'd193);
    tick();
    authorize("t5b", 3'd2, 1'b1);
    load(8'd5);
    check("t5_appr_noload", {24'd0, BALANCE}, 32'd193);
    check("t5_appr_valid", {31'd0, VALID_TRAN}, 32'd1);
    VEND = 1'b1;
    tick();
    VEND = 1'b0;
    check("t5_bal191", {24'd0, BALANCE}, 32'd191);
    check("t5_txn", {24'd0, TXN_COUNT}, 32'd2);

    // 6: COST held after VEND, then reset mid-APPROVED
    COST = 3'd0;
    tick();
    authorize("t6a", 3'd3, 1'b1);
    VEND = 1'b1;
    tick();
    VEND = 1'b0;
    check("t6_bal", {24'd0, BALANCE}, 32'd188);
    check("t6_txn", {24'd0, TXN_COUNT}, 32'd3);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t6_no_reauth", {31'd0, VALID_TRAN}, 32'd0);
    end
    check("t6_bal_hold", {24'd0, BALANCE}, 32'd188);
    COST = 3'd0;
    tick();
    authorize("t6b", 3'd3, 1'b1);
    do_reset("t6_rst");
    check("t6_after_rst_card", {31'd0, CARD_IN}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
